logic_unit_pipe: RTL

- Parametrised, registered successor to the combinational all-gate block: one opcode-selected bitwise operation per transaction instead of seven parallel gate outputs.
- 2-stage valid/ready pipeline (operand register, then result register), plus result flags (zero, all-ones, parity) and a saturating completed-operation counter.
- Sits between an operand source and a result consumer, either of which may stall.

---
 rtl/logic_unit_pkg.sv | 32 +++
 rtl/logic_unit_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and the per-bit operation used by the logic unit.
// The operation is defined on single bits so the package is independent of the data width.
package logic_unit_pkg;

   localparam int OP_WIDTH = 3;

   localparam logic [OP_WIDTH-1:0] OP_AND  = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_OR   = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_NOT  = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_XNOR = 3'd4;
   localparam logic [OP_WIDTH-1:0] OP_NAND = 3'd5;
   localparam logic [OP_WIDTH-1:0] OP_NOR  = 3'd6;
   localparam logic [OP_WIDTH-1:0] OP_PASS = 3'd7;

   function automatic logic logic_op(input logic a, input logic b,
                                     input logic [OP_WIDTH-1:0] op);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NOT:  r = ~a;
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation plus result flags; flags derive from the same y
// so they can never disagree with it.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [OP_WIDTH-1:0]   op,
   output logic [DATA_WIDTH-1:0] y,
   output logic                  zero,
   output logic                  ones,
   output logic                  parity
);

   always_comb begin
      y = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         y[i] = logic_op(a[i], b[i], op);
      end
   end

   assign zero   = ~|y;
   assign ones   = &y;
   assign parity = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit: operand register, then result/flag register,
// with a saturating count of results handed to the consumer.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [DATA_WIDTH-1:0]  a_in,
   input  logic [DATA_WIDTH-1:0]  b_in,
   input  logic [OP_WIDTH-1:0]    op_in,
   input  logic                   valid_in,
   output logic                   ready_out,
   output logic [DATA_WIDTH-1:0]  y_out,
   output logic                   zero_out,
   output logic                   ones_out,
   output logic                   parity_out,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [COUNT_WIDTH-1:0] count_out
);

   logic [DATA_WIDTH-1:0] a_p1;
   logic [DATA_WIDTH-1:0] b_p1;
   logic [OP_WIDTH-1:0]   op_p1;
   logic                  vld_p1;

   logic [DATA_WIDTH-1:0] y_c;
   logic                  zero_c;
   logic                  ones_c;
   logic                  parity_c;

   logic accept;
   logic s2_load;
   logic xfer;

   // ready_out depends combinationally on ready_in so a draining pipe never bubbles
   assign s2_load   = vld_p1 && (!valid_out || ready_in);
   assign ready_out = !rst_in && (!vld_p1 || s2_load);
   assign accept    = valid_in && ready_out;
   assign xfer      = valid_out && ready_in;

   // ---- stage 1: operand register ----
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
      end else if (s2_load) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) begin
         a_p1  <= a_in;
         b_p1  <= b_in;
         op_p1 <= op_in;
      end
   end

   logic_unit_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .a      (a_p1),
      .b      (b_p1),
      .op     (op_p1),
      .y      (y_c),
      .zero   (zero_c),
      .ones   (ones_c),
      .parity (parity_c)
   );

   // ---- stage 2: result and flag register ----
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_out  <= 1'b0;
         y_out      <= '0;
         zero_out   <= 1'b1;
         ones_out   <= 1'b0;
         parity_out <= 1'b0;
      end else if (s2_load) begin
         valid_out  <= 1'b1;
         y_out      <= y_c;
         zero_out   <= zero_c;
         ones_out   <= ones_c;
         parity_out <= parity_c;
      end else if (xfer) begin
         valid_out  <= 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count_out <= '0;
      end else if (xfer && (count_out != '1)) begin
         count_out <= count_out + 1'b1;
      end
   end

endmodule
